// File: rtl/column_scan_sequencer.sv
`default_nettype none
// column_scan_sequencer: for each theta slice, walks the scan positions, fetches panel column groups from the selected
// frame generator over req/valid, masks them, and presents them as valid/ready beats. Aborts the slice if theta changes mid-slice.
module column_scan_sequencer #(
  parameter int ROTATIONAL_RES = 256,
  parameter int NUM_ROWS       = 64,
  parameter int SCAN_RATE      = 32,
  parameter int NUM_PANELS     = 2,
  parameter int RGB_RES        = 9,
  parameter int NUM_SOURCES    = 4,
  parameter int SRC_TIMEOUT    = 15
) (
  input  logic                                     clk_in,
  input  logic                                     rst_in,
  input  logic [$clog2(ROTATIONAL_RES)-1:0]        dtheta,
  input  logic [$clog2(NUM_SOURCES)-1:0]           mode,
  input  logic [NUM_PANELS*SCAN_RATE-1:0]          col_mask,
  output logic                                     src_req,
  output logic [$clog2(NUM_SOURCES)-1:0]           src_sel,
  output logic [$clog2(SCAN_RATE)-1:0]             src_col_idx,
  input  logic                                     src_valid,
  input  logic [NUM_PANELS*NUM_ROWS*RGB_RES-1:0]   src_columns,
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic [NUM_PANELS*NUM_ROWS*RGB_RES-1:0]   out_columns,
  output logic [$clog2(SCAN_RATE)-1:0]             out_col_idx,
  output logic                                     out_first,
  output logic                                     out_last,
  output logic [7:0]                               restart_count,
  output logic [7:0]                               timeout_count
);

  localparam int TW   = $clog2(ROTATIONAL_RES);
  localparam int MW   = $clog2(NUM_SOURCES);
  localparam int CW   = $clog2(SCAN_RATE);
  localparam int COLW = NUM_ROWS * RGB_RES;
  localparam int DW   = NUM_PANELS * COLW;
  localparam int TOW  = $clog2(SRC_TIMEOUT + 1);

  localparam logic [CW-1:0]  LAST_IDX  = CW'(SCAN_RATE - 1);
  localparam logic [TOW-1:0] TO_LAST   = TOW'(SRC_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_WAIT    = 3'd2,
    S_PRESENT = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t          state;
  logic [TW-1:0]   theta_q;
  logic [MW-1:0]   mode_q;
  logic [CW-1:0]   col_idx;
  logic [TOW-1:0]  wait_cnt;

  logic            theta_changed;
  logic [MW-1:0]   mode_eff;
  logic [DW-1:0]   masked;

  assign theta_changed = (dtheta != theta_q);

  // Out-of-range source selects fall back to source 0.
  always_comb begin
    mode_eff = '0;
    for (int s = 0; s < NUM_SOURCES; s++) begin
      if (mode == MW'(s)) mode_eff = mode;
    end
  end

  for (genvar p = 0; p < NUM_PANELS; p++) begin : g_panel
    logic [SCAN_RATE-1:0] panel_mask;
    assign panel_mask = col_mask[p*SCAN_RATE +: SCAN_RATE];
    assign masked[p*COLW +: COLW] = panel_mask[col_idx] ? src_columns[p*COLW +: COLW] : '0;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state         <= S_IDLE;
      theta_q       <= '0;
      mode_q        <= '0;
      col_idx       <= '0;
      wait_cnt      <= '0;
      src_req       <= 1'b0;
      src_sel       <= '0;
      src_col_idx   <= '0;
      out_valid     <= 1'b0;
      out_columns   <= '0;
      out_col_idx   <= '0;
      out_first     <= 1'b0;
      out_last      <= 1'b0;
      restart_count <= '0;
      timeout_count <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          theta_q     <= dtheta;
          mode_q      <= mode_eff;
          col_idx     <= '0;
          src_req     <= 1'b1;
          src_sel     <= mode_eff;
          src_col_idx <= '0;
          state       <= S_FETCH;
        end

        S_FETCH: begin
          src_req  <= 1'b0;
          wait_cnt <= '0;
          if (theta_changed) begin
            if (restart_count != 8'hFF) restart_count <= restart_count + 8'd1;
            state <= S_IDLE;
          end else begin
            state <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (theta_changed) begin
            if (restart_count != 8'hFF) restart_count <= restart_count + 8'd1;
            state <= S_IDLE;
          end else if (src_valid || wait_cnt == TO_LAST) begin
            // A valid arriving on the timeout edge still wins over blanking.
            out_columns <= src_valid ? masked : '0;
            if (!src_valid && timeout_count != 8'hFF) timeout_count <= timeout_count + 8'd1;
            out_valid   <= 1'b1;
            out_col_idx <= col_idx;
            out_first   <= (col_idx == '0);
            out_last    <= (col_idx == LAST_IDX);
            state       <= S_PRESENT;
          end else begin
            wait_cnt <= wait_cnt + TOW'(1);
          end
        end

        S_PRESENT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (col_idx == LAST_IDX) begin
              state <= S_DONE;
            end else begin
              col_idx     <= col_idx + CW'(1);
              src_req     <= 1'b1;
              src_sel     <= mode_q;
              src_col_idx <= col_idx + CW'(1);
              state       <= S_FETCH;
            end
          end else if (theta_changed) begin
            out_valid <= 1'b0;
            if (restart_count != 8'hFF) restart_count <= restart_count + 8'd1;
            state <= S_IDLE;
          end
        end

        S_DONE: begin
          if (theta_changed) state <= S_IDLE;
        end

        default: begin
          out_valid <= 1'b0;
          src_req   <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
